// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT       = 2'd0,
        S_RUN        = 2'd1,
        S_WAIT_FLUSH = 2'd2
    } state_t;

    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    function automatic logic pc_aligned(input logic [31:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_pc_next_sel.sv
// Next-PC priority selection and pending-branch bookkeeping for the fetch stage.
module inst_fetch_pc_next_sel
    import inst_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        stall_if,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        pend_valid,
    input  logic [31:0] pend_target,
    output logic [31:0] pc_next,
    output logic        pend_valid_next,
    output logic [31:0] pend_target_next
);

    always_comb begin
        pc_next          = pc;
        pend_valid_next  = pend_valid;
        pend_target_next = pend_target;
        if (flush) begin
            pc_next          = new_pc;
            pend_valid_next  = 1'b0;
            pend_target_next = ZERO_WORD;
        end else if (stall_if) begin
            // A branch resolved during a fetch stall is remembered, newest wins.
            if (branch_flag) begin
                pend_valid_next  = 1'b1;
                pend_target_next = branch_target;
            end
        end else if (!hold) begin
            if (branch_flag) begin
                pc_next         = branch_target;
                pend_valid_next = 1'b0;
            end else if (pend_valid) begin
                pc_next         = pend_target;
                pend_valid_next = 1'b0;
            end else begin
                pc_next = pc + 32'd4;
            end
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the ROM and fills the IF/ID register.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 1,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_if,
    input  logic             stall_id,
    input  logic             flush,
    input  logic [31:0]      new_pc,
    input  logic             branch_flag,
    input  logic [31:0]      branch_target,
    output logic             rom_ce,
    output logic [31:0]      rom_addr,
    input  logic [31:0]      rom_inst,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_inst,
    output logic             id_valid,
    output logic             id_excp_adel,
    output logic [CNT_W-1:0] fetch_cnt
);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pend_valid;
    logic        pend_valid_next;
    logic [31:0] pend_target;
    logic [31:0] pend_target_next;
    logic [3:0]  boot_cnt;
    logic        hold;

    // The PC only advances while running on an aligned address.
    assign hold     = (state != S_RUN) || !pc_aligned(pc);
    assign rom_ce   = (state == S_RUN) && pc_aligned(pc);
    assign rom_addr = pc;

    inst_fetch_pc_next_sel u_pc_next_sel (
        .pc               (pc),
        .hold             (hold),
        .flush            (flush),
        .new_pc           (new_pc),
        .stall_if         (stall_if),
        .branch_flag      (branch_flag),
        .branch_target    (branch_target),
        .pend_valid       (pend_valid),
        .pend_target      (pend_target),
        .pc_next          (pc_next),
        .pend_valid_next  (pend_valid_next),
        .pend_target_next (pend_target_next)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state        <= S_BOOT;
            pc           <= RESET_PC;
            pend_valid   <= 1'b0;
            pend_target  <= ZERO_WORD;
            boot_cnt     <= 4'(BOOT_CYCLES);
            id_pc        <= ZERO_WORD;
            id_inst      <= ZERO_WORD;
            id_valid     <= 1'b0;
            id_excp_adel <= 1'b0;
            fetch_cnt    <= '0;
        end else begin
            pc          <= pc_next;
            pend_valid  <= pend_valid_next;
            pend_target <= pend_target_next;

            case (state)
                S_BOOT: begin
                    boot_cnt <= boot_cnt - 4'd1;
                    if (boot_cnt <= 4'd1) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!flush && !stall_id && !stall_if && !pc_aligned(pc)) begin
                        state <= S_WAIT_FLUSH;
                    end
                end
                S_WAIT_FLUSH: begin
                    if (flush) begin
                        state <= S_RUN;
                    end
                end
                default: state <= S_BOOT;
            endcase

            // IF/ID register: flush beats stall_id, stall_id beats everything else.
            if (flush || (!stall_id && (stall_if || state != S_RUN))) begin
                id_pc        <= ZERO_WORD;
                id_inst      <= ZERO_WORD;
                id_valid     <= 1'b0;
                id_excp_adel <= 1'b0;
            end else if (!stall_id) begin
                id_pc    <= pc;
                id_valid <= 1'b1;
                if (pc_aligned(pc)) begin
                    id_inst      <= rom_inst;
                    id_excp_adel <= 1'b0;
                    fetch_cnt    <= fetch_cnt + CNT_W'(1);
                end else begin
                    id_inst      <= ZERO_WORD;
                    id_excp_adel <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch initiator: the requesting end of the instruction-memory interface that the combinational instruction ROM answers.
- Owns the PC and drives rom_ce and rom_addr. Captures rom_inst into the IF/ID pipeline register.
- Handles sequential fetch, branch redirect, exception flush, stall and bubble insertion, misaligned-PC detection, and a fetch counter.
- Sits between the control/stall unit, the ID stage and the instruction ROM.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BOOT_CYCLES, 1, cycles rom_ce stays low after reset release (1..15).
- CNT_W, 32, width of the retired-fetch counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- stall_if  in  1  hold the PC (no new fetch accepted).
- stall_id  in  1  hold the IF/ID register.
- flush  in  1  exception flush; redirect to new_pc.
- new_pc  in  32  exception/ERET target.
- branch_flag  in  1  taken branch/jump resolved in ID.
- branch_target  in  32  branch target address.
- rom_ce  out  1  fetch enable to the ROM; the ROM returns zero when low.
- rom_addr  out  32  byte address to the ROM; the ROM indexes it as a word address.
- rom_inst  in  32  ROM data, valid in the same cycle as rom_addr.
- id_pc  out  32  PC of the instruction in IF/ID.
- id_inst  out  32  instruction in IF/ID.
- id_valid  out  1  IF/ID holds a real instruction.
- id_excp_adel  out  1  IF/ID entry is a misaligned-fetch exception.
- fetch_cnt  out  CNT_W  count of instructions loaded into IF/ID.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - state=S_BOOT, pc=RESET_PC, rom_ce=0, rom_addr=RESET_PC;
  - id_pc=0, id_inst=0, id_valid=0, id_excp_adel=0, fetch_cnt=0;
  - pending branch cleared, boot counter=BOOT_CYCLES.
- rst is honoured at any time, including mid-stall or with a pending branch; all state is discarded.
- States:
  - S_BOOT: rom_ce=0. Decrement the boot counter each cycle; go to S_RUN when it reaches 0. flush in S_BOOT loads pc=new_pc and does not shorten the boot delay.
  - S_RUN: rom_ce=1 when pc[1:0]==0. rom_addr=pc combinationally from the pc register.
  - S_WAIT_FLUSH: entered after a misaligned PC is issued to IF/ID. rom_ce=0 and the PC is frozen until flush, then S_RUN.
- Fetch latency:
  - rom_addr is presented in cycle N and rom_inst is sampled at the end of N.
  - id_* is visible in cycle N+1.
  - Sustained throughput is one instruction per cycle.
- Next-PC priority: rst > flush > stall_if > branch > pc+4.
  - flush: pc<=new_pc, pending branch cleared, IF/ID <= bubble (valid=0, inst=0, pc=0). This overrides stall_id.
  - stall_if=1 with branch_flag=1: latch branch_target into the pending register and hold pc.
  - Branch applied: the target is branch_target, or the pending target when stall_if falls.
  - Branch and pending both present: the new branch_flag wins and the pending entry is replaced.
  - pc+4 wraps modulo 2^32; 32'hFFFF_FFFC goes to 0.
- IF/ID update, when not flushed:
  - stall_id=1: hold all id_* outputs.
  - stall_if=1 and stall_id=0: insert a bubble.
  - Otherwise, aligned PC: load id_pc=pc, id_inst=rom_inst, id_valid=1, id_excp_adel=0, and fetch_cnt+=1 (wraps).
  - Otherwise, misaligned PC (pc[1:0]!=0): load id_pc=pc, id_inst=0, id_valid=1, id_excp_adel=1, fetch_cnt unchanged, go to S_WAIT_FLUSH.
- The delay slot is inherent: the instruction after a branch is fetched before the redirect lands and is not killed.
- rom_ce=0 whenever state!=S_RUN or pc is misaligned; rom_addr still shows pc.

Decomposition:
- Add to define.v:
  - `StateBoot`/`StateRun`/`StateWaitFlush` encodings;
  - `RstEnable` (1'b1);
  - `InstAddrBus`/`InstBus` (reuse existing);
  - `ZeroWord` (reuse existing).
- One natural sub-module: pc_next_sel. It is combinational priority selection of next pc and pending-branch update.
- The IF/ID register stays inline.

Test Plan:
- Reset, then BOOT_CYCLES=1, ROM words 0x11,0x22,0x33 -> rom_ce rises 1 cycle after reset release; id_inst=0x11,0x22,0x33 on consecutive cycles; id_pc=0,4,8; fetch_cnt=3.
- Branch_flag=1 with target 0x40 while pc=0x8 -> next rom_addr=0x40. Instruction at 0x8 (delay slot) reaches IF/ID, then the instruction at 0x40.
- stall_if=1 and stall_id=0 for 2 cycles at pc=0x10, with branch_flag pulsed to 0x80 in the first stall cycle -> 2 bubbles (id_valid=0) and pc held at 0x10. After release, rom_addr=0x80.
- Flush with new_pc=0x180 while stall_id=1 and a branch is pending -> IF/ID cleared to a bubble, the pending branch is dropped, and the next rom_addr=0x180.
- Branch to 0x42 -> rom_ce=0, id_excp_adel=1, id_pc=0x42, fetch_cnt unchanged. The block stays in S_WAIT_FLUSH until flush with new_pc=0x180, then resumes at 0x180.
- rst asserted mid-stall with a pending branch -> all outputs return to reset values on the next edge and fetch restarts at RESET_PC.
